// File: rtl/id_ex_hazard_stage_if.sv
// Bundles the ID-side inputs, forwarding sources and ID/EX outputs of the hazard stage.
interface id_ex_hazard_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       id_rd;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [7:0]       id_ctrl;
   logic             ex_flush;
   logic             pipe_hold;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic [XLEN-1:0]  ex_mem_alu_result;
   logic [XLEN-1:0]  mem_wb_wdata;

   logic             stall;
   logic             id_ex_valid;
   logic [4:0]       id_ex_rs1;
   logic [4:0]       id_ex_rs2;
   logic [4:0]       id_ex_rd;
   logic [7:0]       id_ex_ctrl;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic [XLEN-1:0]  store_data;
   logic [CNT_W-1:0] bubble_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl, ex_flush, pipe_hold,
             forward_a, forward_b, ex_mem_alu_result, mem_wb_wdata,
      input  stall, id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl,
             op_a, op_b, store_data, bubble_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl, ex_flush, pipe_hold,
             forward_a, forward_b, ex_mem_alu_result, mem_wb_wdata,
      output stall, id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl,
             op_a, op_b, store_data, bubble_count
   );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use detection, flush/hold/bubble control,
// EX operand forwarding muxes and a saturating load-use bubble counter.
module id_ex_hazard_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   id_ex_hazard_stage_if.slave bus
);
   localparam int MEMREAD_BIT = 6;
   localparam int ALUSRC_BIT  = 3;

   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] rs2_data_q;
   logic [XLEN-1:0] imm_q;
   logic            lu;
   logic [XLEN-1:0] fwd_a_val;
   logic [XLEN-1:0] fwd_b_val;

   always_comb begin
      lu = bus.id_valid && bus.id_ex_valid && bus.id_ex_ctrl[MEMREAD_BIT] &&
           (bus.id_ex_rd != 5'd0) &&
           ((bus.id_uses_rs1 && (bus.id_ex_rd == bus.id_rs1)) ||
            (bus.id_uses_rs2 && (bus.id_ex_rd == bus.id_rs2)));
   end

   assign bus.stall = lu && !bus.ex_flush && !bus.pipe_hold;

   // Select 11 is unused by the forwarding unit and falls back to the register value.
   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                               input logic [XLEN-1:0] reg_val,
                                               input logic [XLEN-1:0] ex_mem_val,
                                               input logic [XLEN-1:0] mem_wb_val);
      case (sel)
         2'b10:   return ex_mem_val;
         2'b01:   return mem_wb_val;
         default: return reg_val;
      endcase
   endfunction

   always_comb begin
      fwd_a_val = fwd_mux(bus.forward_a, rs1_data_q, bus.ex_mem_alu_result, bus.mem_wb_wdata);
      fwd_b_val = fwd_mux(bus.forward_b, rs2_data_q, bus.ex_mem_alu_result, bus.mem_wb_wdata);
   end

   assign bus.op_a       = fwd_a_val;
   assign bus.store_data = fwd_b_val;
   assign bus.op_b       = bus.id_ex_ctrl[ALUSRC_BIT] ? imm_q : fwd_b_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.id_ex_valid  <= 1'b0;
         bus.id_ex_rs1    <= '0;
         bus.id_ex_rs2    <= '0;
         bus.id_ex_rd     <= '0;
         bus.id_ex_ctrl   <= '0;
         rs1_data_q       <= '0;
         rs2_data_q       <= '0;
         imm_q            <= '0;
         bus.bubble_count <= '0;
      end else if (bus.ex_flush || (!bus.pipe_hold && lu)) begin
         // Flush and load-use both inject a bubble; only load-use is counted.
         bus.id_ex_valid <= 1'b0;
         bus.id_ex_rs1   <= '0;
         bus.id_ex_rs2   <= '0;
         bus.id_ex_rd    <= '0;
         bus.id_ex_ctrl  <= '0;
         rs1_data_q      <= '0;
         rs2_data_q      <= '0;
         imm_q           <= '0;
         if (!bus.ex_flush && (bus.bubble_count != '1))
            bus.bubble_count <= bus.bubble_count + 1'b1;
      end else if (!bus.pipe_hold) begin
         bus.id_ex_valid <= bus.id_valid;
         bus.id_ex_rs1   <= bus.id_rs1;
         bus.id_ex_rs2   <= bus.id_rs2;
         bus.id_ex_rd    <= bus.id_rd;
         bus.id_ex_ctrl  <= bus.id_valid ? bus.id_ctrl : 8'd0;
         rs1_data_q      <= bus.id_rs1_data;
         rs2_data_q      <= bus.id_rs2_data;
         imm_q           <= bus.id_imm;
      end
   end
endmodule
